// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM bus arbiter: FSM state encodings and bus constants.
// No logic; types and constants only.
// Imported by every file of the arbiter.
package sram_arbiter_pkg;

  // Two-bit arbiter state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DATA  = 2'b01,
    ST_INST  = 2'b10,
    ST_DRAIN = 2'b11
  } arb_state_t;

  // Instruction fetches always read the full word
  localparam logic [3:0] SEL_ALL = 4'b1111;

endpackage

// File: rtl/sram_arbiter.sv
// Shares one SRAM-style bus between instruction fetch and data access, data first.
// Latency: request registered onto the bus the cycle after ce; result captured on ack edge.
// Backpressure: stallreq_o holds the pipeline until every pending port has its result.
module sram_arbiter
  import sram_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        stallreq_o
);

  arb_state_t state;
  arb_state_t state_nxt;

  // Per-port "result delivered, waiting for the pipeline to move on" flags
  logic d_done;
  logic i_done;

  // One-cycle strobes decoded by the next-state logic
  logic start_data;
  logic start_inst;
  logic cap_data;
  logic cap_inst;
  logic bus_end;

  // Stall while any requesting port has not yet received its result; a flush never stalls
  always_comb begin
    stallreq_o = ((mem_ce_i & ~d_done) | (if_ce_i & ~i_done)) & ~flush;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and strobe decode; a flush turns an in-flight cycle into a drain
  always_comb begin
    state_nxt  = state;
    start_data = 1'b0;
    start_inst = 1'b0;
    cap_data   = 1'b0;
    cap_inst   = 1'b0;
    bus_end    = 1'b0;
    case (state)
      ST_IDLE: begin
        // Acks seen here are stray and ignored
        if (mem_ce_i & ~d_done & ~flush) begin
          state_nxt  = ST_DATA;
          start_data = 1'b1;
        end else if (if_ce_i & ~i_done & ~flush) begin
          state_nxt  = ST_INST;
          start_inst = 1'b1;
        end
      end
      ST_DATA: begin
        if (bus_ack_i) begin
          // Flush on the ack edge discards the result
          state_nxt = ST_IDLE;
          bus_end   = 1'b1;
          cap_data  = ~flush;
        end else if (flush) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_INST: begin
        if (bus_ack_i) begin
          state_nxt = ST_IDLE;
          bus_end   = 1'b1;
          cap_inst  = ~flush;
        end else if (flush) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Let the slave finish the abandoned cycle, then drop it silently
        if (bus_ack_i) begin
          state_nxt = ST_IDLE;
          bus_end   = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Bus request registers: loaded on cycle start, held until the ack ends the cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= 32'h0;
      bus_sel_o   <= 4'b0000;
      bus_wdata_o <= 32'h0;
    end else if (start_data) begin
      bus_req_o   <= 1'b1;
      bus_we_o    <= mem_we_i;
      bus_addr_o  <= mem_addr_i;
      bus_sel_o   <= mem_sel_i;
      bus_wdata_o <= mem_data_i;
    end else if (start_inst) begin
      bus_req_o   <= 1'b1;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= if_addr_i;
      bus_sel_o   <= SEL_ALL;
    end else if (bus_end) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
    end
  end

  // Result capture; stores leave the load-data register untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_data_o <= 32'h0;
      if_data_o  <= 32'h0;
    end else begin
      if (cap_data && !bus_we_o) begin
        mem_data_o <= bus_rdata_i;
      end
      if (cap_inst) begin
        if_data_o <= bus_rdata_i;
      end
    end
  end

  // Done flags: set on a captured ack, cleared once the pipeline advances or flushes
  always_ff @(posedge clk) begin
    if (rst) begin
      d_done <= 1'b0;
      i_done <= 1'b0;
    end else if (flush || !stallreq_o) begin
      d_done <= 1'b0;
      i_done <= 1'b0;
    end else begin
      if (cap_data) begin
        d_done <= 1'b1;
      end
      if (cap_inst) begin
        i_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: load, store with waits, dual request, flush, reset.
// Inputs change 1 ns after the rising edge; outputs are checked after they settle.
// Bus ack is driven by the bench as a simple slave with chosen wait states.
module tb_sram_arbiter;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic        stallreq_o;

  int n_cmp;
  int n_bad;

  sram_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .if_ce_i    (if_ce_i),
    .if_addr_i  (if_addr_i),
    .if_data_o  (if_data_o),
    .mem_ce_i   (mem_ce_i),
    .mem_we_i   (mem_we_i),
    .mem_addr_i (mem_addr_i),
    .mem_sel_i  (mem_sel_i),
    .mem_data_i (mem_data_i),
    .mem_data_o (mem_data_o),
    .bus_req_o  (bus_req_o),
    .bus_we_o   (bus_we_o),
    .bus_addr_o (bus_addr_o),
    .bus_sel_o  (bus_sel_o),
    .bus_wdata_o(bus_wdata_o),
    .bus_ack_i  (bus_ack_i),
    .bus_rdata_i(bus_rdata_i),
    .stallreq_o (stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net: the directed sequence is a few hundred ns long
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, want sequence complete");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and let registered outputs settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs follow freshly driven inputs
  task automatic settle();
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; flush = 1'b0;
    if_ce_i = 1'b0; if_addr_i = 32'h0;
    mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = 32'h0; mem_sel_i = 4'h0; mem_data_i = 32'h0;
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    settle();

    // Reset state
    chk("rst bus_req", {31'h0, bus_req_o}, 32'h0);
    chk("rst bus_we", {31'h0, bus_we_o}, 32'h0);
    chk("rst bus_addr", bus_addr_o, 32'h0);
    chk("rst bus_sel", {28'h0, bus_sel_o}, 32'h0);
    chk("rst bus_wdata", bus_wdata_o, 32'h0);
    chk("rst mem_data", mem_data_o, 32'h0);
    chk("rst if_data", if_data_o, 32'h0);
    chk("rst stall", {31'h0, stallreq_o}, 32'h0);

    // Load with zero-wait ack
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h100; mem_sel_i = 4'hF;
    settle();
    chk("ld c0 stall", {31'h0, stallreq_o}, 32'h1);
    tick();
    chk("ld c1 req", {31'h0, bus_req_o}, 32'h1);
    chk("ld c1 addr", bus_addr_o, 32'h100);
    chk("ld c1 we", {31'h0, bus_we_o}, 32'h0);
    bus_ack_i = 1'b1; bus_rdata_i = 32'hDEADBEEF;
    settle();
    chk("ld c1 stall", {31'h0, stallreq_o}, 32'h1);
    tick();
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    settle();
    chk("ld c2 data", mem_data_o, 32'hDEADBEEF);
    chk("ld c2 req", {31'h0, bus_req_o}, 32'h0);
    chk("ld c2 stall", {31'h0, stallreq_o}, 32'h0);
    tick();
    chk("ld c3 no restart", {31'h0, bus_req_o}, 32'h0);
    mem_ce_i = 1'b0;
    tick();

    // Store and fetch together: data first, one idle cycle, then fetch
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h200; mem_data_i = 32'h11112222; mem_sel_i = 4'hF;
    if_ce_i = 1'b1; if_addr_i = 32'h40;
    tick();
    chk("dual c1 req", {31'h0, bus_req_o}, 32'h1);
    chk("dual c1 we", {31'h0, bus_we_o}, 32'h1);
    chk("dual c1 addr", bus_addr_o, 32'h200);
    chk("dual c1 wdata", bus_wdata_o, 32'h11112222);
    bus_ack_i = 1'b1;
    tick();
    bus_ack_i = 1'b0;
    settle();
    chk("dual c2 idle req", {31'h0, bus_req_o}, 32'h0);
    chk("dual c2 stall", {31'h0, stallreq_o}, 32'h1);
    chk("dual c2 mem_data kept", mem_data_o, 32'hDEADBEEF);
    tick();
    chk("dual c3 req", {31'h0, bus_req_o}, 32'h1);
    chk("dual c3 we", {31'h0, bus_we_o}, 32'h0);
    chk("dual c3 addr", bus_addr_o, 32'h40);
    chk("dual c3 sel", {28'h0, bus_sel_o}, 32'hF);
    chk("dual c3 stall", {31'h0, stallreq_o}, 32'h1);
    bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFEF00D;
    tick();
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    settle();
    chk("dual c4 if_data", if_data_o, 32'hCAFEF00D);
    chk("dual c4 req", {31'h0, bus_req_o}, 32'h0);
    chk("dual c4 stall", {31'h0, stallreq_o}, 32'h0);
    mem_ce_i = 1'b0; if_ce_i = 1'b0; mem_we_i = 1'b0;
    tick();

    // Store with three wait cycles: bus held for four cycles
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h300; mem_sel_i = 4'b0011; mem_data_i = 32'h12345678;
    tick();
    mem_addr_i = 32'hFFFF_FFFF; mem_data_i = 32'h0; mem_sel_i = 4'hF;
    for (int i = 0; i < 4; i++) begin
      chk("st hold req", {31'h0, bus_req_o}, 32'h1);
      chk("st hold we", {31'h0, bus_we_o}, 32'h1);
      chk("st hold addr", bus_addr_o, 32'h300);
      chk("st hold sel", {28'h0, bus_sel_o}, 32'h3);
      chk("st hold wdata", bus_wdata_o, 32'h12345678);
      if (i == 3) bus_ack_i = 1'b1;
      bus_rdata_i = 32'h5A5A5A5A;
      tick();
    end
    bus_ack_i = 1'b0;
    settle();
    chk("st end req", {31'h0, bus_req_o}, 32'h0);
    chk("st end we", {31'h0, bus_we_o}, 32'h0);
    chk("st mem_data kept", mem_data_o, 32'hDEADBEEF);
    chk("st end stall", {31'h0, stallreq_o}, 32'h0);
    mem_ce_i = 1'b0; mem_we_i = 1'b0;
    tick();

    // Flush during a fetch: drain the bus cycle and drop its data
    if_ce_i = 1'b1; if_addr_i = 32'h80;
    tick();
    chk("fl c1 req", {31'h0, bus_req_o}, 32'h1);
    chk("fl c1 addr", bus_addr_o, 32'h80);
    flush = 1'b1;
    settle();
    chk("fl c1 stall", {31'h0, stallreq_o}, 32'h0);
    tick();
    flush = 1'b0; if_ce_i = 1'b0;
    settle();
    chk("fl drain req", {31'h0, bus_req_o}, 32'h1);
    chk("fl drain addr", bus_addr_o, 32'h80);
    bus_ack_i = 1'b1; bus_rdata_i = 32'hAAAA5555;
    tick();
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    settle();
    chk("fl if_data kept", if_data_o, 32'hCAFEF00D);
    chk("fl stall", {31'h0, stallreq_o}, 32'h0);
    chk("fl req", {31'h0, bus_req_o}, 32'h0);
    // Drained ack must not mark the fetch done
    if_ce_i = 1'b1; if_addr_i = 32'h84;
    settle();
    chk("fl refetch stall", {31'h0, stallreq_o}, 32'h1);
    tick();
    chk("fl refetch addr", bus_addr_o, 32'h84);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h00000013;
    tick();
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    settle();
    chk("fl refetch data", if_data_o, 32'h00000013);
    if_ce_i = 1'b0;
    tick();

    // Stray ack in IDLE is ignored
    bus_ack_i = 1'b1; bus_rdata_i = 32'h55555555;
    tick();
    bus_ack_i = 1'b0;
    settle();
    chk("idle ack req", {31'h0, bus_req_o}, 32'h0);
    chk("idle ack mem_data", mem_data_o, 32'hDEADBEEF);
    chk("idle ack if_data", if_data_o, 32'h00000013);

    // Reset mid-DATA abandons the cycle; a late ack changes nothing
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h500;
    tick();
    chk("rd c1 req", {31'h0, bus_req_o}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_ce_i = 1'b0;
    settle();
    chk("rd req", {31'h0, bus_req_o}, 32'h0);
    chk("rd addr", bus_addr_o, 32'h0);
    chk("rd mem_data", mem_data_o, 32'h0);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h99999999;
    tick();
    bus_ack_i = 1'b0;
    settle();
    chk("rd late ack mem_data", mem_data_o, 32'h0);
    chk("rd late ack req", {31'h0, bus_req_o}, 32'h0);

    // Flush on the ack edge wins: result dropped, access retried
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h600; mem_sel_i = 4'hF;
    tick();
    chk("fa c1 req", {31'h0, bus_req_o}, 32'h1);
    flush = 1'b1; bus_ack_i = 1'b1; bus_rdata_i = 32'h77777777;
    tick();
    flush = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    settle();
    chk("fa req", {31'h0, bus_req_o}, 32'h0);
    chk("fa mem_data", mem_data_o, 32'h0);
    chk("fa stall", {31'h0, stallreq_o}, 32'h1);
    tick();
    chk("fa retry req", {31'h0, bus_req_o}, 32'h1);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h88888888;
    tick();
    bus_ack_i = 1'b0;
    settle();
    chk("fa retry data", mem_data_o, 32'h88888888);
    chk("fa retry stall", {31'h0, stallreq_o}, 32'h0);
    mem_ce_i = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
